seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_dec.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LAMP  = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;

    localparam logic [3:0] AN_OFF = 4'hF;

    typedef enum logic {
        S_GAP = 1'b0,
        S_ON  = 1'b1
    } scan_state_t;

    // Leading-zero blank mask for digits 3..1; digit 0 is always shown.
    function automatic logic [3:0] lz_blank(input logic [15:0] val, input logic en);
        logic [3:0] b;
        b[3] = en && (val[15:12] == 4'h0);
        b[2] = b[3] && (val[11:8] == 4'h0);
        b[1] = b[2] && (val[7:4] == 4'h0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/seg_dec.sv
// BCD nibble to active-low seven-segment pattern; 4'hF lights every segment,
// 4'hA..4'hE go dark.
module seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hF:    seg = SEG_LAMP;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scanner with per-slot blanking gap,
// frame-synchronous display update, leading-zero blanking and blink.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int GAP          = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] din,
    input  logic        lzb_en,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(GAP);
    localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    dig, dig_n;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          pend_v;
    logic [BW-1:0] bcnt;
    logic          blink_off;
    logic          bound;
    logic [3:0]    blank;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;

    seg_dec u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    assign nib   = disp[{dig, 2'b00} +: 4];
    assign blank = lz_blank(disp, lzb_en);
    assign bound = (dig == 2'd3) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_GAP;
            cnt   <= '0;
            dig   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dig   <= dig_n;
        end
    end

    // State tracks cnt<GAP one cycle ahead so it stays aligned with cnt.
    always_comb begin
        cnt_n   = cnt + 1'b1;
        dig_n   = dig;
        if (cnt == CNT_LAST) begin
            cnt_n = '0;
            dig_n = dig + 2'd1;
        end
        state_n = (cnt_n < CNT_GAP) ? S_GAP : S_ON;

        an_n  = AN_OFF;
        seg_n = SEG_BLANK;
        if (state == S_ON && !(blink_en && blink_off) && !blank[dig]) begin
            an_n[dig] = 1'b0;
            seg_n     = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            frame <= 1'b0;
        end else begin
            an    <= an_n;
            seg   <= seg_n;
            frame <= bound;
        end
    end

    // A coincident ld still lets the old pending value reach disp first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp   <= 16'h0000;
            pend   <= 16'h0000;
            pend_v <= 1'b0;
        end else begin
            if (bound && pend_v) disp <= pend;
            if (ld) begin
                pend   <= din;
                pend_v <= 1'b1;
            end else if (bound) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !blink_en) begin
            bcnt      <= '0;
            blink_off <= 1'b0;
        end else if (bound) begin
            if (bcnt == BLNK_LAST) begin
                bcnt      <= '0;
                blink_off <= ~blink_off;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at DIV=8, GAP=2, BLINK_FRAMES=2: expected
// per-cycle an/seg/frame for a whole frame are queued, then popped and compared.
module tb_seg_scan_ctrl;

    localparam int DIV = 8;
    localparam int GAP = 2;
    localparam int BF  = 2;
    localparam int FRAME_CYC = 4 * DIV;

    logic        clk, rst_n, ld, lzb_en, blink_en;
    logic [15:0] din;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    seg_scan_ctrl #(.DIV(DIV), .GAP(GAP), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .din      (din),
        .lzb_en   (lzb_en),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .frame    (frame)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       seg_chk;
        logic       frame;
    } exp_t;

    typedef struct {
        logic [15:0]      din;
        logic             lzb;
        logic [3:0]       lit;
        logic [3:0][6:0]  segs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_ld(input logic [15:0] d, input logic lzb);
        lzb_en = lzb;
        din    = d;
        ld     = 1'b1;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 4 * FRAME_CYC);
        checks++;
        if (!frame) begin
            errors++;
            $display("FAIL frame_timeout: got no frame pulse in %0d cycles", n);
        end
    endtask

    // Call from the negedge of the cycle carrying a frame pulse (cnt=0, dig=0).
    task automatic run_frame(input logic [3:0] lit, input logic [3:0][6:0] segs,
                             input logic dark);
        exp_t e;
        for (int j = 0; j < FRAME_CYC; j++) begin
            int slot = j / DIV;
            int c    = j % DIV;
            e.an      = 4'hF;
            e.seg     = 7'h7F;
            e.seg_chk = 1'b1;
            e.frame   = (j == FRAME_CYC - 1);
            if (c < GAP && !dark) e.seg_chk = 1'b0;
            else if (!dark && lit[slot]) begin
                e.an       = 4'hF;
                e.an[slot] = 1'b0;
                e.seg      = segs[slot];
            end
            sb.push_back(e);
        end
        for (int j = 0; j < FRAME_CYC; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("an[j=%0d]", j), 32'(an), 32'(e.an));
            if (e.seg_chk) chk($sformatf("seg[j=%0d]", j), 32'(seg), 32'(e.seg));
            chk($sformatf("frame[j=%0d]", j), 32'(frame), 32'(e.frame));
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0070, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'hFFFF, 1'b1, 4'b1111, {7'h00, 7'h00, 7'h00, 7'h00}};
        vecs[4] = '{16'h0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h5678, 1'b0, 4'b1111, {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[6] = '{16'h9AE0, 1'b1, 4'b1111, {7'h18, 7'h7F, 7'h7F, 7'h40}};
        vecs[7] = '{16'h0100, 1'b1, 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[8] = '{16'h0005, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h12}};

        rst_n = 1'b0; ld = 1'b0; din = 16'h0; lzb_en = 1'b0; blink_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_frame", 32'(frame), 32'h0);

        // First frame after reset shows disp=0 with no blanking.
        rst_n = 1'b1;
        run_frame(4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);

        foreach (vecs[i]) begin
            wait_frame();
            do_ld(vecs[i].din, vecs[i].lzb);
            wait_frame();
            run_frame(vecs[i].lit, vecs[i].segs, 1'b0);
        end

        // Second ld in the same frame overwrites the first.
        wait_frame();
        do_ld(16'h1111, 1'b0);
        repeat (5) @(negedge clk);
        do_ld(16'h2222, 1'b0);
        wait_frame();
        run_frame(4'b1111, {7'h24, 7'h24, 7'h24, 7'h24}, 1'b0);

        // ld on the boundary edge: old pending goes to disp, din waits a frame.
        wait_frame();
        do_ld(16'h3333, 1'b0);
        repeat (FRAME_CYC - 2) @(negedge clk);
        do_ld(16'h4444, 1'b0);
        run_frame(4'b1111, {7'h30, 7'h30, 7'h30, 7'h30}, 1'b0);
        // Boundary ld with nothing pending leaves disp unchanged.
        repeat (FRAME_CYC - 1) @(negedge clk);
        do_ld(16'h5555, 1'b0);
        run_frame(4'b1111, {7'h19, 7'h19, 7'h19, 7'h19}, 1'b0);
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b0);

        // Blink: two lit frames, two dark frames, then lit again.
        blink_en = 1'b1;
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b0);
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b0);
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b1);
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b1);
        run_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 1'b0);
        blink_en = 1'b0;

        // Reset mid-slot with a value pending: scan restarts, pending lost.
        wait_frame();
        do_ld(16'h6666, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'h0000000F);
        chk("midrst_seg", 32'(seg), 32'h0000007F);
        chk("midrst_frame", 32'(frame), 32'h0);
        rst_n = 1'b1;
        run_frame(4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
        run_frame(4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
